// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
//
// Front-end of the SHA-256 datapath. It collects a message that arrives as
// big-endian 32-bit words, appends the standard padding, and hands complete
// 512-bit blocks to the compression core over a valid/ready handshake.
// The padding is a 0x80 byte, zero fill, and the 64-bit message bit length.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   input word valid
//   in_ready   padder can accept an input word this cycle
//   in_data    message word, first byte in [31:24]
//   in_last    word is the final word of the message
//   in_nbytes  valid bytes in the last word (MSB-aligned), 0 means 4
//   out_valid  out_block holds a complete block
//   out_ready  core accepts the block
//   out_block  block, word 0 in [511:480], word 15 in [31:0]
//   out_last   block is the final block of the message
//   blk_count  (only with SHA256_PAD_BLKCNT_EN) blocks handed over so far in
//              the current message, including the one in a handshake
//
// Optional feature macro: SHA256_PAD_BLKCNT_EN
//
// There is a single block buffer. Input words are written straight into it,
// and the same buffer drives out_block, so input and output transfers never
// overlap.
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_nbytes,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_last
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  typedef enum logic [2:0] {
    FILL,
    PAD,
    EMIT,
    EXTRA,
    EMIT_FINAL
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] words [16];
  logic [3:0]  k;
  logic [60:0] byte_cnt;
  logic        extra_pend;
  logic        extra_80;
  logic        started;

  logic        accept;
  logic        hs;
  logic [2:0]  add_bytes;
  logic [60:0] cnt_next;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] len_cur;
  logic [31:0] last_word;
  logic        full_last;
  logic [4:0]  p;
  logic [4:0]  k_ext;

  // Handshake qualifiers. in_ready is held low until the first clock edge
  // after reset so a source cannot slip a word in while reset is releasing.
  assign in_ready  = started && (state == FILL);
  assign out_valid = (state == EMIT) || (state == EMIT_FINAL);
  assign out_last  = (state == EMIT_FINAL);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;

  // Byte accounting: a last word contributes in_nbytes bytes (0 encodes 4),
  // any other word contributes a full 4. The bit length is the byte count
  // shifted by three, so it wraps modulo 2^64 along with the 61-bit counter.
  assign add_bytes = (in_last && (in_nbytes != 2'd0)) ? {1'b0, in_nbytes} : 3'd4;
  assign cnt_next  = byte_cnt + 61'(add_bytes);
  assign len_next  = {cnt_next, 3'b000};
  assign len_cur   = {byte_cnt, 3'b000};

  // A last word that is completely full pushes the 0x80 marker into the
  // next word slot, so the marker's word index p is one past k.
  assign full_last = in_last && (in_nbytes == 2'd0);
  assign k_ext     = {1'b0, k};
  assign p         = full_last ? (k_ext + 5'd1) : k_ext;

  // Build the last data word: keep the valid MSB-aligned bytes, force the
  // unused bytes to zero, and drop the 0x80 marker right after the data.
  always_comb begin
    last_word = in_data;
    case (in_nbytes)
      2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  // Map the word buffer onto the block bus with word 0 in the top bits.
  always_comb begin
    out_block = '0;
    for (int i = 0; i < 16; i++) begin
      out_block[511 - 32*i -: 32] = words[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A last word whose marker lands at p<=13 leaves room
  // for the length in the same block; otherwise an extra block follows.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept) begin
          if (in_last) begin
            state_next = (p <= 5'd13) ? EMIT_FINAL : EMIT;
          end else if (k == 4'd15) begin
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (hs) begin
          state_next = extra_pend ? EXTRA : FILL;
        end
      end
      EXTRA: begin
        state_next = EMIT_FINAL;
      end
      EMIT_FINAL: begin
        if (hs) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Datapath: word buffer, word index, byte counter and extra-block flags.
  // Non-last words are written at k. A last word also zeroes everything
  // after it and, when it fits, writes the length into words 14..15.
  // EXTRA rebuilds the whole buffer as the trailing padding block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        words[i] <= '0;
      end
      k          <= '0;
      byte_cnt   <= '0;
      extra_pend <= 1'b0;
      extra_80   <= 1'b0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        FILL: begin
          if (accept) begin
            byte_cnt <= cnt_next;
            k        <= k + 4'd1;
            if (!in_last) begin
              words[k] <= in_data;
            end else begin
              for (int i = 0; i < 16; i++) begin
                if (5'(i) == k_ext) begin
                  words[i] <= last_word;
                end else if (5'(i) > k_ext) begin
                  if (full_last && (5'(i) == k_ext + 5'd1)) begin
                    words[i] <= 32'h8000_0000;
                  end else if ((p <= 5'd13) && (i == 14)) begin
                    words[i] <= len_next[LEN_W-1 -: 32];
                  end else if ((p <= 5'd13) && (i == 15)) begin
                    words[i] <= len_next[31:0];
                  end else begin
                    words[i] <= '0;
                  end
                end
              end
              extra_pend <= (p > 5'd13);
              extra_80   <= full_last && (k == 4'd15);
            end
          end
        end
        EXTRA: begin
          for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
              words[i] <= extra_80 ? 32'h8000_0000 : 32'h0000_0000;
            end else if (i == 14) begin
              words[i] <= len_cur[LEN_W-1 -: 32];
            end else if (i == 15) begin
              words[i] <= len_cur[31:0];
            end else begin
              words[i] <= '0;
            end
          end
          extra_pend <= 1'b0;
          extra_80   <= 1'b0;
        end
        EMIT_FINAL: begin
          if (hs) begin
            byte_cnt <= '0;
            k        <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  // Per-message block counter. The registered value counts completed
  // handshakes; the output adds the one in progress so the final handshake
  // shows the message's block total, after which the count restarts.
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (hs) begin
      blk_cnt_q <= out_last ? 32'd0 : (blk_cnt_q + 32'd1);
    end
  end

  assign blk_count = blk_cnt_q + 32'(hs);
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
//
// Directed bench for sha256_msg_padder. Expected blocks come from a
// byte-level padding model and wait in a scoreboard queue until the DUT
// presents them.
// Optional feature macro: SHA256_PAD_BLKCNT_EN (enables blk_count checks).
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [1:0]   in_nbytes = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_block;
  logic         out_last;
`ifdef SHA256_PAD_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  typedef struct {
    logic [511:0] block;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   blk_model = 0;

  sha256_msg_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_last  (out_last)
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports tag, observed and expected.
  task automatic check_output(input string tag, input logic [511:0] obs,
                              input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference padding on a byte stream: append 0x80, zero-fill to 56 mod 64,
  // append the 64-bit big-endian bit length, then cut into 64-byte blocks.
  task automatic build_expected(input logic [7:0] msg[$]);
    logic [7:0]  pad[$];
    logic [63:0] bits;
    exp_t        e;
    int          nblk;
    pad  = msg;
    bits = 64'(msg.size()) * 64'd8;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    for (int j = 7; j >= 0; j--) pad.push_back(bits[8*j +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.block = '0;
      for (int j = 0; j < 64; j++) e.block[511 - 8*j -: 8] = pad[64*b + j];
      e.last = (b == nblk - 1);
      sb.push_back(e);
    end
  endtask

  // Drive one word and wait (bounded) for it to be accepted.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    in_nbytes = nb;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check_output("in_ready_timeout", in_ready, 1'b1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_data   = $urandom;
    in_last   = 1'($urandom);
    in_nbytes = 2'($urandom);
  endtask

  // Wait for a block, hold it under backpressure, then take it and compare
  // against the oldest scoreboard entry.
  task automatic collect_block(input int hold);
    exp_t e;
    int   waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("out_valid_wait", out_valid, 1'b1);
    if (sb.size() == 0) begin
      check_output("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_output("hold_block", out_block, e.block);
      check_output("hold_valid", out_valid, 1'b1);
      check_output("hold_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    check_output("block", out_block, e.block);
    check_output("last", out_last, e.last);
    check_output("busy_in_ready", in_ready, 1'b0);
`ifdef SHA256_PAD_BLKCNT_EN
    check_output("blk_count_pre", blk_count, 32'(blk_model));
`endif
    out_ready = 1'b1;
    #1;
`ifdef SHA256_PAD_BLKCNT_EN
    check_output("blk_count_hs", blk_count, 32'(blk_model + 1));
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    blk_model = e.last ? 0 : blk_model + 1;
  endtask

  // Send a random message of nwords words (last word carries last_nb bytes,
  // 0 meaning 4) and collect every block it produces.
  task automatic apply_stimulus(input int nwords, input int last_nb, input int hold);
    logic [7:0]  msg[$];
    logic [31:0] w[$];
    logic [31:0] d;
    int          nb;
    for (int i = 0; i < nwords; i++) begin
      d = $urandom;
      w.push_back(d);
      nb = (i == nwords - 1 && last_nb != 0) ? last_nb : 4;
      for (int j = 0; j < nb; j++) msg.push_back(d[31 - 8*j -: 8]);
    end
    build_expected(msg);
    for (int i = 0; i < nwords; i++) begin
      if (i == nwords - 1) send_word(w[i], 1'b1, 2'(last_nb));
      else                 send_word(w[i], 1'b0, 2'($urandom));
      if ((i % 16) == 15 || i == nwords - 1) begin
        check_output("latency", out_valid, 1'b1);
        collect_block(hold);
      end
    end
    if (sb.size() > 0) begin
      check_output("extra_gap", out_valid, 1'b0);
      @(posedge clk); #1;
      check_output("extra_latency", out_valid, 1'b1);
      collect_block(hold);
    end
    check_output("ready_after", in_ready, 1'b1);
  endtask

  // "abc" with garbage in the unused byte; checks the literal block too.
  task automatic send_abc(input int hold);
    logic [7:0] msg[$];
    msg = '{8'h61, 8'h62, 8'h63};
    build_expected(msg);
    send_word(32'h6162_63A5, 1'b1, 2'd3);
    check_output("abc_latency", out_valid, 1'b1);
    check_output("abc_word0", out_block[511:480], 32'h6162_6380);
    check_output("abc_mid", out_block[479:32], '0);
    check_output("abc_word15", out_block[31:0], 32'h0000_0018);
    collect_block(hold);
    check_output("abc_ready_after", in_ready, 1'b1);
  endtask

  initial begin
    #3;
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_last", out_last, 1'b0);
    check_output("rst_out_block", out_block, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rst_release_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check_output("ready_rise", in_ready, 1'b1);

    $display("[TB] abc");
    send_abc(0);
    $display("[TB] 55 bytes");
    apply_stimulus(14, 3, 0);
    $display("[TB] 56 bytes");
    apply_stimulus(14, 0, 0);
    $display("[TB] 64 bytes");
    apply_stimulus(16, 0, 0);
    $display("[TB] 52, 59, 60 and 70 bytes");
    apply_stimulus(13, 0, 0);
    apply_stimulus(15, 3, 0);
    apply_stimulus(15, 0, 2);
    apply_stimulus(18, 2, 1);

    $display("[TB] backpressure");
    send_abc(10);

    $display("[TB] reset mid-message");
    for (int i = 0; i < 7; i++) send_word($urandom | 32'h1, 1'b0, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rst_in_ready", in_ready, 1'b0);
    check_output("mid_rst_out_valid", out_valid, 1'b0);
    check_output("mid_rst_out_last", out_last, 1'b0);
    check_output("mid_rst_out_block", out_block, '0);
    blk_model = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("mid_rst_release", in_ready, 1'b0);
    @(posedge clk); #1;
    check_output("mid_rst_ready_rise", in_ready, 1'b1);
    send_abc(0);

    check_output("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Front-end of the SHA-256 datapath. Accepts a message as a stream of big-endian 32-bit words.
- Appends the standard padding: a 0x80 byte, zero fill, and the 64-bit message bit-length.
- Delivers complete 512-bit blocks to the compression core over a valid/ready handshake, flagging the final block of each message.
- It is the producer end of the block interface that the round logic (Ch/Maj/Σ) consumes.

Parameters:
- LEN_W, 64, width of the message bit-length field appended in words 14..15; fixed by SHA-256, not to be overridden.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  padder can accept an input word this cycle
- in_data  input  32  message word; first byte in [31:24]
- in_last  input  1  word is the final word of the message
- in_nbytes  input  2  valid bytes in a last word, MSB-aligned; 0 means 4, 1..3 literal; ignored when in_last=0
- out_valid  output  1  out_block holds a complete block
- out_ready  input  1  core accepts the block
- out_block  output  512  block; word 0 in [511:480], word 15 in [31:0]
- out_last  output  1  block is the final block of the message

Behaviour:
- Reset (async, rst=1): in_ready=0, out_valid=0, out_last=0, out_block=0, byte counter=0, word index=0, state=FILL. in_ready rises on the first clk edge after rst deasserts.
- Reset mid-operation discards any partial message and any pending block. The input source must restart its message.
- States: FILL, PAD, EMIT, EXTRA, EMIT_FINAL.
- FILL:
  - in_ready=1.
  - Accepting a word (in_valid & in_ready) writes it to word index k, advances k, and adds 4 bytes (or nbytes if last) to the byte counter.
  - Non-last word with k=15 goes to EMIT with out_last=0, then k wraps to 0.
- Last word:
  - Bytes beyond nbytes are forced to 0.
  - The 0x80 byte is placed at the first free byte position. Its word index is p=k if nbytes<4, else p=k+1.
  - If p≤13: remaining words are zeroed, words 14..15 get the bit length (bytes×8, mod 2^64), and state goes to EMIT_FINAL.
  - If p=14 or 15: remaining words are zeroed and state goes to EMIT (out_last=0), then EXTRA.
  - If p=16 (last word filled index 15 completely): state goes to EMIT, then EXTRA with word 0 = 0x80000000.
- PAD is an internal single-cycle fill/length-insert state. Using it is optional, but output timing must equal the latency rule below.
- EXTRA: builds the extra block (0x80 word if pending, zeros, length in words 14..15), then goes to EMIT_FINAL.
- EMIT / EMIT_FINAL:
  - out_valid=1, in_ready=0, out_block stable until out_valid & out_ready.
  - On handshake, EMIT goes to FILL, or EXTRA if pending.
  - On handshake, EMIT_FINAL goes to FILL, clears the byte counter, and resets k=0.
- Latency: out_valid asserts the cycle after the accepting edge of the word that completes or terminates a block. Add one cycle when EXTRA is needed.
- A new block can be accepted in FILL the cycle after the output handshake. No input and output transfer ever occur in the same cycle (single block buffer).
- Byte counter is 61 bits and wraps silently. Bit length = counter<<3.
- Empty messages are not supported; every message carries at least one word with in_last=1.
- in_data/in_last/in_nbytes are sampled only on handshake. Values while in_ready=0 are ignored.

Optional Feature:
- Macro: SHA256_PAD_BLKCNT_EN.
- Defined: adds output blk_count [31:0]. It increments on each output handshake, resets to 0 on rst, and clears to 0 on the handshake following an out_last=1 block (so it reads the block total during the final-block handshake).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- "abc": one word 0x61626300, last, nbytes=3 -> single block, word0=0x61626380, words1..14=0, word15=0x00000018, out_last=1, out_valid one cycle after the accept.
- 55 bytes (13 full words + last nbytes=3) -> single block, 0x80 in word13 [7:0], word15=0x000001B8, out_last=1.
- 56 bytes (14 words, last nbytes=0) -> block1 word14=0x80000000, word15=0, out_last=0; block2 words0..13=0, word15=0x000001C0, out_last=1.
- 64 bytes (16 words, last nbytes=0) -> block1 = raw data, out_last=0; block2 word0=0x80000000, word15=0x00000200, out_last=1.
- Backpressure: hold out_ready=0 for 10 cycles during the "abc" block -> out_valid and out_block stable, in_ready=0 throughout; handshake on release, in_ready=1 next cycle.
- Reset: assert rst after 7 words of a message -> outputs zero immediately; a subsequent "abc" message yields exactly the "abc" block above (with SHA256_PAD_BLKCNT_EN, blk_count=0 before and 1 during its handshake).
